// File: rtl/gate_guard_pkg.sv
// Shared types and helpers for the gate-drive guard: leg states, decoded leg
// requests, and the mapping from leg number to pwm/gate bit position.
package gate_guard_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'b00,
        ON_H = 2'b01,
        ON_L = 2'b10
    } leg_state_t;

    typedef enum logic [1:0] {
        REQ_NONE = 2'b00,
        REQ_H    = 2'b01,
        REQ_L    = 2'b10
    } leg_req_t;

    // Leg k owns bit 2k (high-side switch) and bit 2k+1 (low-side switch).
    function automatic int hi_idx(input int k);
        return 2 * k;
    endfunction

    function automatic int lo_idx(input int k);
        return 2 * k + 1;
    endfunction

    // req[0] is the high-side request, req[1] the low-side request.
    // Both requested together is a firmware fault and is treated as no request.
    function automatic leg_req_t decode_req(input logic [1:0] req);
        case (req)
            2'b01:   return REQ_H;
            2'b10:   return REQ_L;
            default: return REQ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/gate_leg_guard.sv
// One complementary leg: request decode, OFF/ON_H/ON_L state machine,
// dead-time and minimum-pulse counters, and the registered gate pair.
module gate_leg_guard
    import gate_guard_pkg::*;
#(
    parameter int DEADTIME_CYC  = 50,
    parameter int MIN_PULSE_CYC = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       force_off,
    input  logic       allow_on,
    output logic [1:0] gate,
    output logic       st_err
);

    localparam int DT_W = $clog2(DEADTIME_CYC + 1);
    localparam int PW_W = $clog2(MIN_PULSE_CYC + 1);
    localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME_CYC);
    localparam logic [PW_W-1:0] PW_LOAD = PW_W'(MIN_PULSE_CYC - 1);

    leg_state_t      state;
    leg_state_t      state_nxt;
    leg_req_t        req_kind;
    logic [DT_W-1:0] dt_cnt;
    logic [DT_W-1:0] dt_nxt;
    logic [DT_W-1:0] dt_dec;
    logic [PW_W-1:0] pw_cnt;
    logic [PW_W-1:0] pw_nxt;
    logic [PW_W-1:0] pw_dec;
    logic            req_match;
    logic            leave_on;

    assign req_kind  = decode_req(req);
    assign st_err    = &req;
    assign dt_dec    = (dt_cnt == '0) ? '0 : dt_cnt - 1'b1;
    assign pw_dec    = (pw_cnt == '0) ? '0 : pw_cnt - 1'b1;
    assign req_match = ((state == ON_H) && (req_kind == REQ_H)) ||
                       ((state == ON_L) && (req_kind == REQ_L));
    assign leave_on  = force_off || ((pw_cnt == '0) && !req_match);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_nxt = state;
        dt_nxt    = dt_cnt;
        pw_nxt    = pw_cnt;
        case (state)
            OFF: begin
                dt_nxt = dt_dec;
                // Dead time ends in the cycle the counter reaches zero, so both
                // gates are low for exactly DEADTIME_CYC cycles.
                if ((dt_dec == '0) && allow_on && !force_off && (req_kind != REQ_NONE)) begin
                    state_nxt = (req_kind == REQ_H) ? ON_H : ON_L;
                    pw_nxt    = PW_LOAD;
                end
            end
            ON_H, ON_L: begin
                if (leave_on) begin
                    state_nxt = OFF;
                    dt_nxt    = DT_LOAD;
                end else begin
                    pw_nxt = pw_dec;
                end
            end
            default: begin
                state_nxt = OFF;
                dt_nxt    = DT_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state  <= OFF;
            dt_cnt <= DT_LOAD;
            pw_cnt <= '0;
            gate   <= 2'b00;
        end else begin
            state  <= state_nxt;
            dt_cnt <= dt_nxt;
            pw_cnt <= pw_nxt;
            gate   <= {state_nxt == ON_L, state_nxt == ON_H};
        end
    end

endmodule

// File: rtl/gate_drive_guard.sv
// Guard stage between the PWM accelerator and the H-bridge gate drivers.
// Optional build macro GATE_DRIVE_GUARD_VIOL_CNT_EN adds the viol_cnt output.
module gate_drive_guard
    import gate_guard_pkg::*;
#(
    parameter int NUM_LEGS      = 4,
    parameter int DEADTIME_CYC  = 50,
    parameter int MIN_PULSE_CYC = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [2*NUM_LEGS-1:0] pwm_in,
    input  logic                  kill,
    input  logic                  fault_clr,
    input  logic                  sticky_clr,
    output logic [2*NUM_LEGS-1:0] gate_out,
    output logic                  faulted,
    output logic [NUM_LEGS-1:0]   shoot_thru_err
`ifdef GATE_DRIVE_GUARD_VIOL_CNT_EN
    ,
    output logic [15:0]           viol_cnt
`endif
);

    logic [2*NUM_LEGS-1:0] req_q;
    logic [NUM_LEGS-1:0]   st_err;
    logic                  force_off;
    logic                  allow_on;

    // kill and enable act on the very next edge; the latched fault only blocks
    // new turn-ons until firmware clears it.
    assign force_off = kill | ~enable;
    assign allow_on  = enable & ~faulted;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q          <= '0;
            faulted        <= 1'b0;
            shoot_thru_err <= '0;
        end else begin
            req_q <= pwm_in;
            if (kill) begin
                faulted <= 1'b1;
            end else if (fault_clr) begin
                faulted <= 1'b0;
            end
            shoot_thru_err <= st_err | (shoot_thru_err & ~{NUM_LEGS{sticky_clr}});
        end
    end

    for (genvar k = 0; k < NUM_LEGS; k++) begin : g_leg
        logic [1:0] leg_gate;

        gate_leg_guard #(
            .DEADTIME_CYC  (DEADTIME_CYC),
            .MIN_PULSE_CYC (MIN_PULSE_CYC)
        ) u_leg (
            .clk       (clk),
            .rst       (rst),
            .req       ({req_q[lo_idx(k)], req_q[hi_idx(k)]}),
            .force_off (force_off),
            .allow_on  (allow_on),
            .gate      (leg_gate),
            .st_err    (st_err[k])
        );

        assign gate_out[hi_idx(k)] = leg_gate[0];
        assign gate_out[lo_idx(k)] = leg_gate[1];
    end

`ifdef GATE_DRIVE_GUARD_VIOL_CNT_EN
    localparam int RC_W = $clog2(NUM_LEGS + 1);

    logic [NUM_LEGS-1:0] st_err_q;
    logic [NUM_LEGS-1:0] st_rise;
    logic [RC_W-1:0]     rise_cnt;
    logic [16:0]         viol_sum;

    assign st_rise  = st_err & ~st_err_q;
    assign viol_sum = {1'b0, viol_cnt} + 17'(rise_cnt);

    always_comb begin
        rise_cnt = '0;
        for (int k = 0; k < NUM_LEGS; k++) begin
            rise_cnt = rise_cnt + RC_W'(st_rise[k]);
        end
    end

    // A new violation in the same cycle as sticky_clr is counted, not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_err_q <= '0;
            viol_cnt <= '0;
        end else begin
            st_err_q <= st_err;
            if (rise_cnt != '0) begin
                viol_cnt <= viol_sum[16] ? 16'hFFFF : viol_sum[15:0];
            end else if (sticky_clr) begin
                viol_cnt <= '0;
            end
        end
    end
`else
    // Default build: no violation counter.
`endif

endmodule

// File: tb/tb_gate_drive_guard.sv
// Self-checking bench for gate_drive_guard (DEADTIME_CYC=4, MIN_PULSE_CYC=3):
// directed vector table, then a randomised run against a reference model.
module tb_gate_drive_guard;

    localparam int NL = 4;
    localparam int DT = 4;
    localparam int MP = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [2*NL-1:0] pwm_in;
    logic          kill;
    logic          fault_clr;
    logic          sticky_clr;
    logic [2*NL-1:0] gate_out;
    logic          faulted;
    logic [NL-1:0] shoot_thru_err;
`ifdef GATE_DRIVE_GUARD_VIOL_CNT_EN
    logic [15:0]   viol_cnt;
`endif

    gate_drive_guard #(
        .NUM_LEGS      (NL),
        .DEADTIME_CYC  (DT),
        .MIN_PULSE_CYC (MP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .pwm_in         (pwm_in),
        .kill           (kill),
        .fault_clr      (fault_clr),
        .sticky_clr     (sticky_clr),
        .gate_out       (gate_out),
        .faulted        (faulted),
        .shoot_thru_err (shoot_thru_err)
`ifdef GATE_DRIVE_GUARD_VIOL_CNT_EN
        ,
        .viol_cnt       (viol_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, en, kill, fclr, sclr;
        logic [7:0] pwm;
        logic [7:0] gate;
        logic       flt;
        logic [3:0] st;
        logic [15:0] viol;
    } vec_t;

    typedef struct {
        logic [7:0]  gate;
        logic        flt;
        logic [3:0]  st;
        logic [15:0] viol;
        int          tag;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    vec_t tbl[$];
    exp_t sb_q[$];

    // Reference model state: cycles spent low / high per leg instead of counters.
    logic [7:0] m_req;
    int         m_state [NL];
    int         m_low   [NL];
    int         m_high  [NL];
    logic       m_flt;
    logic [3:0] m_st;
    logic [3:0] m_prev;
    int         m_viol;

    task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at step %0d: got %0h, expected %0h", name, tag, act, req);
        end
    endtask

    task automatic add(input int reps, input logic r, input logic en, input logic kl, input logic fc,
                       input logic sc, input logic [7:0] pwm, input logic [7:0] gate, input logic flt,
                       input logic [3:0] st, input logic [15:0] viol);
        vec_t v;
        v = '{rst: r, en: en, kill: kl, fclr: fc, sclr: sc, pwm: pwm, gate: gate, flt: flt, st: st, viol: viol};
        for (int i = 0; i < reps; i++) tbl.push_back(v);
    endtask

    task automatic model_step(input vec_t v, output exp_t e);
        int         want;
        int         done;
        int         inc;
        logic       allow;
        logic       force_off;
        logic [3:0] eleven;
        if (v.rst) begin
            m_req = '0; m_flt = 1'b0; m_st = '0; m_prev = '0; m_viol = 0;
            for (int k = 0; k < NL; k++) begin
                m_state[k] = 0; m_low[k] = 0; m_high[k] = 0;
            end
        end else begin
            force_off = v.kill | ~v.en;
            allow     = v.en & ~m_flt;
            for (int k = 0; k < NL; k++) begin
                eleven[k] = m_req[2*k] & m_req[2*k+1];
                want = (m_req[2*k] && !m_req[2*k+1]) ? 1 : (!m_req[2*k] && m_req[2*k+1]) ? 2 : 0;
                if (m_state[k] == 0) begin
                    done = (m_low[k] + 1 > DT) ? DT : m_low[k] + 1;
                    if (done >= DT && want != 0 && allow && !force_off) begin
                        m_state[k] = want; m_high[k] = 0;
                    end else begin
                        m_low[k] = done;
                    end
                end else if (force_off) begin
                    m_state[k] = 0; m_low[k] = 0;
                end else begin
                    done = (m_high[k] + 1 > MP) ? MP : m_high[k] + 1;
                    if (done >= MP && want != m_state[k]) begin
                        m_state[k] = 0; m_low[k] = 0;
                    end else begin
                        m_high[k] = done;
                    end
                end
            end
            inc = $countones(eleven & ~m_prev);
            m_prev = eleven;
            m_st = eleven | (m_st & ~{4{v.sclr}});
            if (inc != 0) m_viol = (m_viol + inc > 65535) ? 65535 : m_viol + inc;
            else if (v.sclr) m_viol = 0;
            if (v.kill) m_flt = 1'b1;
            else if (v.fclr) m_flt = 1'b0;
            m_req = v.pwm;
        end
        for (int k = 0; k < NL; k++) begin
            e.gate[2*k]   = (m_state[k] == 1);
            e.gate[2*k+1] = (m_state[k] == 2);
        end
        e.flt  = m_flt;
        e.st   = m_st;
        e.viol = 16'(m_viol);
    endtask

    // Drive one cycle of stimulus, queue its expected result, compare after the edge.
    task automatic apply(input vec_t v, input exp_t e);
        exp_t got;
        rst = v.rst; enable = v.en; kill = v.kill;
        fault_clr = v.fclr; sticky_clr = v.sclr; pwm_in = v.pwm;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got = sb_q.pop_front();
        check("gate_out", got.tag, 32'(gate_out), 32'(got.gate));
        check("faulted", got.tag, 32'(faulted), 32'(got.flt));
        check("shoot_thru_err", got.tag, 32'(shoot_thru_err), 32'(got.st));
`ifdef GATE_DRIVE_GUARD_VIOL_CNT_EN
        check("viol_cnt", got.tag, 32'(viol_cnt), 32'(got.viol));
`endif
        for (int k = 0; k < NL; k++)
            check("no_shoot_thru", got.tag, 32'(gate_out[2*k] & gate_out[2*k+1]), 32'd0);
    endtask

    initial begin
        vec_t       v;
        exp_t       e;
        logic [7:0] rpwm;
        logic [7:0] pg;
        logic       forced;
        logic       on_now;
        logic       on_was;
        int         low_run  [NL];
        int         high_run [NL];
        int         r;

        rst = 1'b1; enable = 1'b0; kill = 1'b0; fault_clr = 1'b0; sticky_clr = 1'b0; pwm_in = '0;
        @(negedge clk);

        //   reps rst en kl fc sc pwm    gate   flt st    viol
        add(2,  1, 1, 0, 0, 0, 8'h01, 8'h00, 0, 4'h0, 16'd0);  // held in reset
        add(3,  0, 1, 0, 0, 0, 8'h01, 8'h00, 0, 4'h0, 16'd0);  // dead time from reset
        add(3,  0, 1, 0, 0, 0, 8'h01, 8'h01, 0, 4'h0, 16'd0);  // hi rises 4 edges after release
        add(1,  0, 1, 0, 0, 0, 8'h02, 8'h01, 0, 4'h0, 16'd0);  // request lo; one cycle of latency
        add(4,  0, 1, 0, 0, 0, 8'h02, 8'h00, 0, 4'h0, 16'd0);  // exactly 4 dead cycles
        add(3,  0, 1, 0, 0, 0, 8'h02, 8'h02, 0, 4'h0, 16'd0);  // lo on
        add(1,  0, 1, 0, 0, 0, 8'h01, 8'h02, 0, 4'h0, 16'd0);
        add(4,  0, 1, 0, 0, 0, 8'h01, 8'h00, 0, 4'h0, 16'd0);
        add(3,  0, 1, 0, 0, 0, 8'h00, 8'h01, 0, 4'h0, 16'd0);  // request drops right after turn-on
        add(1,  0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 4'h0, 16'd0);  // min pulse of 3 held
        add(3,  0, 1, 0, 0, 0, 8'h01, 8'h00, 0, 4'h0, 16'd0);
        add(1,  0, 1, 0, 0, 0, 8'h00, 8'h01, 0, 4'h0, 16'd0);  // one-cycle drop...
        add(3,  0, 1, 0, 0, 0, 8'h01, 8'h01, 0, 4'h0, 16'd0);  // ...returns in time: no gap
        add(1,  0, 1, 0, 0, 0, 8'h03, 8'h01, 0, 4'h0, 16'd0);
        add(2,  0, 1, 0, 0, 0, 8'h03, 8'h00, 0, 4'h1, 16'd1);  // 11 request: off, sticky set
        add(1,  0, 1, 0, 0, 1, 8'h00, 8'h00, 0, 4'h1, 16'd0);  // set wins over clear
        add(1,  0, 1, 0, 0, 1, 8'h00, 8'h00, 0, 4'h0, 16'd0);  // clear
        add(1,  0, 1, 0, 0, 0, 8'h55, 8'h00, 0, 4'h0, 16'd0);
        add(2,  0, 1, 0, 0, 0, 8'h55, 8'h55, 0, 4'h0, 16'd0);  // all legs on
        add(1,  0, 1, 1, 0, 0, 8'h55, 8'h00, 1, 4'h0, 16'd0);  // kill overrides min pulse
        add(1,  0, 1, 1, 1, 0, 8'h55, 8'h00, 1, 4'h0, 16'd0);  // clear ignored under kill
        add(1,  0, 1, 0, 1, 0, 8'h55, 8'h00, 0, 4'h0, 16'd0);  // clear accepted
        add(1,  0, 1, 0, 0, 0, 8'h55, 8'h00, 0, 4'h0, 16'd0);
        add(1,  0, 1, 0, 0, 0, 8'h55, 8'h55, 0, 4'h0, 16'd0);  // back after 4 dead cycles
        add(1,  0, 0, 0, 0, 0, 8'h55, 8'h00, 0, 4'h0, 16'd0);  // enable low forces off
        add(3,  0, 1, 0, 0, 0, 8'h55, 8'h00, 0, 4'h0, 16'd0);
        add(1,  0, 1, 0, 0, 0, 8'h55, 8'h55, 0, 4'h0, 16'd0);
        add(1,  1, 1, 0, 0, 0, 8'h55, 8'h00, 0, 4'h0, 16'd0);  // reset mid-pulse
        add(3,  0, 1, 0, 0, 0, 8'h55, 8'h00, 0, 4'h0, 16'd0);
        add(1,  0, 1, 0, 0, 0, 8'h55, 8'h55, 0, 4'h0, 16'd0);

        foreach (tbl[i]) begin
            e = '{gate: tbl[i].gate, flt: tbl[i].flt, st: tbl[i].st, viol: tbl[i].viol, tag: i};
            apply(tbl[i], e);
        end

        // Randomised run: model scoreboard plus per-leg timing properties.
        rpwm = '0;
        pg   = gate_out;
        for (int k = 0; k < NL; k++) begin
            low_run[k] = 0; high_run[k] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            v.rst  = (c == 0) || ($urandom_range(0, 299) == 0);
            v.en   = ($urandom_range(0, 49) != 0);
            v.kill = ($urandom_range(0, 79) == 0);
            v.fclr = ($urandom_range(0, 9) == 0);
            v.sclr = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < NL; k++) begin
                if ($urandom_range(0, 5) == 0) begin
                    r = $urandom_range(0, 9);
                    rpwm[2*k +: 2] = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r < 9) ? 2'b00 : 2'b11;
                end
            end
            v.pwm = rpwm;
            v.gate = '0; v.flt = 1'b0; v.st = '0; v.viol = '0;
            model_step(v, e);
            e.tag = 1000 + c;
            apply(v, e);
            forced = v.rst | v.kill | ~v.en;
            for (int k = 0; k < NL; k++) begin
                on_now = gate_out[2*k] | gate_out[2*k+1];
                on_was = pg[2*k] | pg[2*k+1];
                if (on_now && !on_was) begin
                    check("dead_gap", e.tag, 32'(low_run[k] >= DT), 32'd1);
                    high_run[k] = 1;
                end else if (!on_now && on_was) begin
                    if (!forced) check("min_pulse", e.tag, 32'(high_run[k] >= MP), 32'd1);
                    low_run[k] = 1;
                end else if (on_now) begin
                    check("direct_swap", e.tag, 32'(gate_out[2*k +: 2]), 32'(pg[2*k +: 2]));
                    high_run[k]++;
                end else begin
                    low_run[k]++;
                end
            end
            pg = gate_out;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
